// File: rtl/extbus_if_if.sv
// Bus-pin and register-file signal bundle for the extbus_if host front end.
// The slave modport is the front end; the master modport is the host/register-file side.
`timescale 1ns/1ps

interface extbus_if_if;
  logic       extbus_cs_n;
  logic       extbus_rd_n;
  logic       extbus_wr_n;
  logic [4:0] extbus_a;
  logic [7:0] extbus_d_in;
  logic [7:0] extbus_d_out;
  logic       extbus_d_oe;
  logic [4:0] rd_addr;
  logic [7:0] reg_rddata;
  logic       reg_wr;
  logic [4:0] reg_wr_addr;
  logic [7:0] reg_wr_data;
  logic       reg_rd_done;
  logic [4:0] reg_rd_done_addr;

  modport slave (
    input  extbus_cs_n, extbus_rd_n, extbus_wr_n, extbus_a, extbus_d_in, reg_rddata,
    output extbus_d_out, extbus_d_oe, rd_addr,
    output reg_wr, reg_wr_addr, reg_wr_data, reg_rd_done, reg_rd_done_addr
  );

  modport master (
    output extbus_cs_n, extbus_rd_n, extbus_wr_n, extbus_a, extbus_d_in, reg_rddata,
    input  extbus_d_out, extbus_d_oe, rd_addr,
    input  reg_wr, reg_wr_addr, reg_wr_data, reg_rd_done, reg_rd_done_addr
  );
endinterface

// File: rtl/extbus_if.sv
// Host-bus front end: synchronises async strobes into clk25 and emits one
// register-write or read-done pulse per completed bus cycle.
`timescale 1ns/1ps

module extbus_if #(
  parameter int SYNC_STAGES = 2
) (
  input logic        clk25,
  input logic        rst_n,
  extbus_if_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WR, RD} state_t;

  logic [SYNC_STAGES-1:0] cs_sync_reg, rd_sync_reg, wr_sync_reg;
  logic                   cs_s, rd_s, wr_s;
  logic [4:0]             a_q_reg;
  logic [7:0]             d_q_reg;
  logic [12:0]            cap_reg;
  logic [4:0]             rd_addr_reg;
  state_t                 state_reg, state_next;
  logic                   wr_pulse_next, rd_pulse_next, rd_latch_next;
  logic                   reg_wr_reg, reg_rd_done_reg;
  logic [4:0]             reg_wr_addr_reg, reg_rd_done_addr_reg;
  logic [7:0]             reg_wr_data_reg;

  // Read path is purely combinational so data meets the phi2-high window.
  assign bus.extbus_d_oe  = !bus.extbus_cs_n && !bus.extbus_rd_n;
  assign bus.extbus_d_out = bus.reg_rddata;
  assign bus.rd_addr      = bus.extbus_a;

  assign cs_s = cs_sync_reg[SYNC_STAGES-1];
  assign rd_s = rd_sync_reg[SYNC_STAGES-1];
  assign wr_s = wr_sync_reg[SYNC_STAGES-1];

  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      cs_sync_reg <= '1;
      rd_sync_reg <= '1;
      wr_sync_reg <= '1;
    end else begin
      cs_sync_reg <= {cs_sync_reg[SYNC_STAGES-2:0], bus.extbus_cs_n};
      rd_sync_reg <= {rd_sync_reg[SYNC_STAGES-2:0], bus.extbus_rd_n};
      wr_sync_reg <= {wr_sync_reg[SYNC_STAGES-2:0], bus.extbus_wr_n};
    end
  end

  // Capture follows the bus while the write is active, so it ends up holding
  // the last address/data seen before wr_n rose.
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      a_q_reg <= '0;
      d_q_reg <= '0;
      cap_reg <= '0;
    end else begin
      a_q_reg <= bus.extbus_a;
      d_q_reg <= bus.extbus_d_in;
      if (!wr_sync_reg[0] && !cs_sync_reg[0])
        cap_reg <= {a_q_reg, d_q_reg};
    end
  end

  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next    = state_reg;
    wr_pulse_next = 1'b0;
    rd_pulse_next = 1'b0;
    rd_latch_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!cs_s && !wr_s) begin
          state_next = WR;
        end else if (!cs_s && !rd_s) begin
          state_next    = RD;
          rd_latch_next = 1'b1;
        end
      end
      WR: begin
        if (wr_s || cs_s) begin
          state_next    = IDLE;
          wr_pulse_next = 1'b1;
        end
      end
      RD: begin
        if (rd_s || cs_s) begin
          state_next    = IDLE;
          rd_pulse_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      rd_addr_reg          <= '0;
      reg_wr_reg           <= 1'b0;
      reg_rd_done_reg      <= 1'b0;
      reg_wr_addr_reg      <= '0;
      reg_wr_data_reg      <= '0;
      reg_rd_done_addr_reg <= '0;
    end else begin
      reg_wr_reg      <= wr_pulse_next;
      reg_rd_done_reg <= rd_pulse_next;
      if (rd_latch_next)
        rd_addr_reg <= a_q_reg;
      if (wr_pulse_next) begin
        reg_wr_addr_reg <= cap_reg[12:8];
        reg_wr_data_reg <= cap_reg[7:0];
      end
      if (rd_pulse_next)
        reg_rd_done_addr_reg <= rd_addr_reg;
    end
  end

  assign bus.reg_wr           = reg_wr_reg;
  assign bus.reg_wr_addr      = reg_wr_addr_reg;
  assign bus.reg_wr_data      = reg_wr_data_reg;
  assign bus.reg_rd_done      = reg_rd_done_reg;
  assign bus.reg_rd_done_addr = reg_rd_done_addr_reg;

endmodule

// File: tb/tb_extbus_if.sv
// Directed bench for extbus_if: stimulus pushes expected pulses into a queue,
// a negedge monitor pops and compares every reg_wr / reg_rd_done it sees.
`timescale 1ns/1ps

module tb_extbus_if;

  typedef struct {
    bit         is_wr;
    logic [4:0] addr;
    logic [7:0] data;
  } exp_t;

  logic clk25 = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;
  int   n_wr  = 0;
  int   n_rd  = 0;
  exp_t sb[$];

  localparam int PHI = 62;

  extbus_if_if bus();

  extbus_if #(.SYNC_STAGES(2)) dut (
    .clk25(clk25),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #20 clk25 = ~clk25;

  // Register-file read model: address 0x04 returns 0x5A.
  assign bus.reg_rddata = 8'h56 + {3'b000, bus.rd_addr};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic bit selected(input logic [15:0] addr);
    return addr[15:5] == 11'h4F9;
  endfunction

  // Monitor: one line per pulse observed.
  always @(negedge clk25) begin
    if (bus.reg_wr || bus.reg_rd_done) begin
      exp_t e;
      total++;
      if (bus.reg_wr) n_wr++;
      if (bus.reg_rd_done) n_rd++;
      if (bus.reg_wr && bus.reg_rd_done) begin
        bad++;
        $display("FAIL pulse_overlap: got wr=1 rd_done=1 expected at most one");
      end else if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_pulse: got %s addr=0x%0h expected none",
                 bus.reg_wr ? "wr" : "rd_done",
                 bus.reg_wr ? bus.reg_wr_addr : bus.reg_rd_done_addr);
      end else begin
        e = sb.pop_front();
        if (e.is_wr) begin
          if (!bus.reg_wr || bus.reg_wr_addr !== e.addr || bus.reg_wr_data !== e.data) begin
            bad++;
            $display("FAIL wr_txn: got wr=%0b addr=0x%0h data=0x%0h expected wr addr=0x%0h data=0x%0h",
                     bus.reg_wr, bus.reg_wr_addr, bus.reg_wr_data, e.addr, e.data);
          end else
            $display("txn wr addr=0x%0h data=0x%0h ok", bus.reg_wr_addr, bus.reg_wr_data);
        end else begin
          if (!bus.reg_rd_done || bus.reg_rd_done_addr !== e.addr) begin
            bad++;
            $display("FAIL rd_txn: got rd_done=%0b addr=0x%0h expected rd_done addr=0x%0h",
                     bus.reg_rd_done, bus.reg_rd_done_addr, e.addr);
          end else
            $display("txn rd_done addr=0x%0h ok", bus.reg_rd_done_addr);
        end
      end
    end
  end

  // One 8 MHz phi2 bus write: strobe high for phi1, low for phi2.
  task automatic bus_write(input logic [15:0] addr, input logic [7:0] data);
    bus.extbus_a    = addr[4:0];
    bus.extbus_d_in = data;
    bus.extbus_cs_n = !selected(addr);
    if (selected(addr)) sb.push_back('{1'b1, addr[4:0], data});
    #PHI;
    bus.extbus_wr_n = 1'b0;
    #PHI;
    bus.extbus_wr_n = 1'b1;
    #1;
    bus.extbus_cs_n = 1'b1;
  endtask

  task automatic bus_read(input logic [15:0] addr, input logic [7:0] exp_data);
    bus.extbus_a    = addr[4:0];
    bus.extbus_cs_n = !selected(addr);
    if (selected(addr)) sb.push_back('{1'b0, addr[4:0], 8'h00});
    #PHI;
    bus.extbus_rd_n = 1'b0;
    #(PHI/2);
    chk("rd_oe_active", {31'd0, bus.extbus_d_oe}, {31'd0, selected(addr)});
    if (selected(addr)) chk("rd_data", {24'd0, bus.extbus_d_out}, {24'd0, exp_data});
    #(PHI/2);
    bus.extbus_rd_n = 1'b1;
    #1;
    bus.extbus_cs_n = 1'b1;
    chk("rd_oe_released", {31'd0, bus.extbus_d_oe}, 32'd0);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_reg_wr"},           {31'd0, bus.reg_wr},           32'd0);
    chk({tag, "_reg_rd_done"},      {31'd0, bus.reg_rd_done},      32'd0);
    chk({tag, "_reg_wr_addr"},      {27'd0, bus.reg_wr_addr},      32'd0);
    chk({tag, "_reg_wr_data"},      {24'd0, bus.reg_wr_data},      32'd0);
    chk({tag, "_reg_rd_done_addr"}, {27'd0, bus.reg_rd_done_addr}, 32'd0);
  endtask

  logic [7:0] burst [4] = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};

  initial begin
    int n0;
    bus.extbus_cs_n = 1'b1;
    bus.extbus_rd_n = 1'b1;
    bus.extbus_wr_n = 1'b1;
    bus.extbus_a    = '0;
    bus.extbus_d_in = '0;

    repeat (2) @(negedge clk25);
    chk_outputs_zero("reset");
    chk("reset_d_oe", {31'd0, bus.extbus_d_oe}, 32'd0);
    #7 rst_n = 1'b1;
    repeat (3) @(negedge clk25);

    // Single write, then check the pulse lands within 4 clk25 of wr_n rising.
    n0 = n_wr;
    bus_write(16'h9F25, 8'h01);
    repeat (4) @(posedge clk25);
    @(negedge clk25);
    #1;
    chk("wr_latency_count", n_wr, n0 + 1);

    // Setup writes then four back-to-back data-port writes.
    bus_write(16'h9F20, 8'h00);
    bus_write(16'h9F21, 8'h40);
    bus_write(16'h9F22, 8'h10);
    for (int i = 0; i < 4; i++) bus_write(16'h9F24, burst[i]);
    repeat (6) @(negedge clk25);

    // Four consecutive reads of the data port.
    for (int i = 0; i < 4; i++) bus_read(16'h9F24, 8'h5A);
    repeat (6) @(negedge clk25);

    // Unselected accesses: no pulses, no output enable.
    bus_write(16'h1003, 8'h77);
    bus_read(16'h1003, 8'h00);
    repeat (6) @(negedge clk25);

    // Reset in the middle of a write: no pulse for that bus cycle.
    bus.extbus_a    = 5'h07;
    bus.extbus_d_in = 8'hEE;
    bus.extbus_cs_n = 1'b0;
    #PHI;
    bus.extbus_wr_n = 1'b0;
    repeat (4) @(posedge clk25);
    #5 rst_n = 1'b0;
    #1;
    chk_outputs_zero("midreset");
    repeat (2) @(negedge clk25);
    bus.extbus_wr_n = 1'b1;
    bus.extbus_cs_n = 1'b1;
    repeat (2) @(posedge clk25);
    #3 rst_n = 1'b1;
    repeat (10) @(negedge clk25);
    chk("post_reset_no_wr", {31'd0, bus.reg_wr_addr == 5'h07}, 32'd0);
    bus_write(16'h9F27, 8'h3C);
    repeat (6) @(negedge clk25);

    // rd_n and wr_n together: write only.
    n0 = n_rd;
    bus.extbus_a    = 5'h0B;
    bus.extbus_d_in = 8'hC5;
    bus.extbus_cs_n = 1'b0;
    sb.push_back('{1'b1, 5'h0B, 8'hC5});
    #PHI;
    bus.extbus_rd_n = 1'b0;
    bus.extbus_wr_n = 1'b0;
    #PHI;
    bus.extbus_rd_n = 1'b1;
    bus.extbus_wr_n = 1'b1;
    #1;
    bus.extbus_cs_n = 1'b1;

    repeat (10) @(negedge clk25);
    chk("both_low_no_rd_done", n_rd, n0);
    chk("scoreboard_drained", sb.size(), 0);
    chk("total_wr_pulses", n_wr, 10);
    chk("total_rd_pulses", n_rd, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
